decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 331 +++++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// LEGv8 instruction decode stage with a single holding register and a
// load-use scoreboard.
//
// A fetched instruction is decoded combinationally and captured in the holding
// register when fetch presents it and decode can accept it. The held
// instruction is offered to execute unless one of its source registers is
// still waiting on an LDUR result. LDUR results are tracked by a LOAD_LAT-deep
// shift register of (valid, rd). A flush kills the held instruction.
//
// Parameters
//   DATA_W    width of id_imm (must be >= 26 to hold the widest immediate)
//   LOAD_LAT  cycles a loaded register stays pending after LDUR issue (1..4)
//   CNT_W     width of stall_cnt
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   if_valid / if_instr   fetch presents a 32-bit instruction word
//   if_ready              decode accepts the instruction this cycle
//   flush                 taken branch: kill the held instruction
//   id_ready              execute accepts the decoded instruction
//   id_valid              decoded instruction is valid
//   id_op                 0 NOP, 1 ADDI, 2 ADDS, 3 SUBS, 4 B, 5 BLT, 6 CBZ,
//                         7 LDUR, 8 STUR, 9 LSL, 10 LSR, 11 MUL, 15 ILLEGAL
//   id_rd/id_rn/id_rm     register fields (0 when the format has none)
//   id_imm                selected, extended immediate
//   id_shamt              shift amount (LSL/LSR only)
//   id_regwrite, id_memrd, id_memwr, id_setflags   control bits
//   id_illegal            opcode not recognised
//   stall_cnt             saturating count of hazard-stall cycles
//
// Configuration
//   DECODE_MUL_EN  defined: MUL (opcode 0x4D8) decodes as op 11.
//                  undefined: opcode 0x4D8 decodes as ILLEGAL.
// -----------------------------------------------------------------------------
module decode_stage #(
  parameter int DATA_W   = 64,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  output logic              if_ready,
  input  logic              flush,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [3:0]        id_op,
  output logic [4:0]        id_rd,
  output logic [4:0]        id_rn,
  output logic [4:0]        id_rm,
  output logic [DATA_W-1:0] id_imm,
  output logic [5:0]        id_shamt,
  output logic              id_regwrite,
  output logic              id_memrd,
  output logic              id_memwr,
  output logic              id_setflags,
  output logic              id_illegal,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [3:0] {
    OP_NOP     = 4'd0,
    OP_ADDI    = 4'd1,
    OP_ADDS    = 4'd2,
    OP_SUBS    = 4'd3,
    OP_B       = 4'd4,
    OP_BLT     = 4'd5,
    OP_CBZ     = 4'd6,
    OP_LDUR    = 4'd7,
    OP_STUR    = 4'd8,
    OP_LSL     = 4'd9,
    OP_LSR     = 4'd10,
    OP_MUL     = 4'd11,
    OP_ILLEGAL = 4'd15
  } op_e;

  // Decoded instruction as held between fetch and execute. The use_* flags
  // mark which register fields are sources, for the hazard check.
  typedef struct packed {
    op_e               op;
    logic [4:0]        rd;
    logic [4:0]        rn;
    logic [4:0]        rm;
    logic [DATA_W-1:0] imm;
    logic [5:0]        shamt;
    logic              regwrite;
    logic              memrd;
    logic              memwr;
    logic              setflags;
    logic              illegal;
    logic              use_rn;
    logic              use_rm;
    logic              use_rd;
  } dec_t;

  // Opcode field values
  localparam logic [9:0]  OPC_ADDI = 10'h244;  // [31:22]
  localparam logic [5:0]  OPC_B    = 6'h05;    // [31:26]
  localparam logic [7:0]  OPC_BLT  = 8'h54;    // [31:24]
  localparam logic [7:0]  OPC_CBZ  = 8'hB4;    // [31:24]
  localparam logic [10:0] OPC_ADDS = 11'h558;  // [31:21] from here on
  localparam logic [10:0] OPC_SUBS = 11'h758;
  localparam logic [10:0] OPC_LSL  = 11'h69B;
  localparam logic [10:0] OPC_LSR  = 11'h69A;
  localparam logic [10:0] OPC_MUL  = 11'h4D8;
  localparam logic [10:0] OPC_STUR = 11'h7C0;
  localparam logic [10:0] OPC_LDUR = 11'h7C2;

  localparam logic [4:0]  XZR = 5'd31;

  // ---------------------------------------------------------------------------
  // Opcode recognition
  // ---------------------------------------------------------------------------
  op_e op_d;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin : op_recognise
    op_d = OP_ILLEGAL;
    if (if_instr[31:22] == OPC_ADDI) begin
      op_d = OP_ADDI;
    end else if (if_instr[31:26] == OPC_B) begin
      op_d = OP_B;
    end else if (if_instr[31:24] == OPC_BLT) begin
      op_d = OP_BLT;
    end else if (if_instr[31:24] == OPC_CBZ) begin
      op_d = OP_CBZ;
    end else begin
      unique case (if_instr[31:21])
        OPC_ADDS: op_d = OP_ADDS;
        OPC_SUBS: op_d = OP_SUBS;
        OPC_LSL:  op_d = OP_LSL;
        OPC_LSR:  op_d = OP_LSR;
`ifdef DECODE_MUL_EN
        OPC_MUL:  op_d = OP_MUL;
`endif
        OPC_STUR: op_d = OP_STUR;
        OPC_LDUR: op_d = OP_LDUR;
        default:  op_d = OP_ILLEGAL;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Field extraction: fields a format does not use stay at the zero default.
  // ---------------------------------------------------------------------------
  dec_t dec_d;

  always_comb begin : field_decode
    dec_d    = '0;
    dec_d.op = op_d;
    unique case (op_d)
      OP_ADDI: begin
        dec_d.rd       = if_instr[4:0];
        dec_d.rn       = if_instr[9:5];
        dec_d.imm      = {{(DATA_W-12){1'b0}}, if_instr[21:10]};
        dec_d.regwrite = 1'b1;
        dec_d.use_rn   = 1'b1;
      end
      OP_ADDS, OP_SUBS, OP_MUL: begin
        dec_d.rd       = if_instr[4:0];
        dec_d.rn       = if_instr[9:5];
        dec_d.rm       = if_instr[20:16];
        dec_d.regwrite = 1'b1;
        dec_d.setflags = (op_d != OP_MUL);
        dec_d.use_rn   = 1'b1;
        dec_d.use_rm   = 1'b1;
      end
      OP_LSL, OP_LSR: begin
        dec_d.rd       = if_instr[4:0];
        dec_d.rn       = if_instr[9:5];
        dec_d.shamt    = if_instr[15:10];
        dec_d.regwrite = 1'b1;
        dec_d.use_rn   = 1'b1;
      end
      OP_LDUR: begin
        dec_d.rd       = if_instr[4:0];
        dec_d.rn       = if_instr[9:5];
        dec_d.imm      = {{(DATA_W-9){if_instr[20]}}, if_instr[20:12]};
        dec_d.regwrite = 1'b1;
        dec_d.memrd    = 1'b1;
        dec_d.use_rn   = 1'b1;
      end
      OP_STUR: begin
        // The stored register lives in the rd field and is a source.
        dec_d.rd     = if_instr[4:0];
        dec_d.rn     = if_instr[9:5];
        dec_d.imm    = {{(DATA_W-9){if_instr[20]}}, if_instr[20:12]};
        dec_d.memwr  = 1'b1;
        dec_d.use_rn = 1'b1;
        dec_d.use_rd = 1'b1;
      end
      OP_B: begin
        dec_d.imm = {{(DATA_W-26){if_instr[25]}}, if_instr[25:0]};
      end
      OP_BLT: begin
        // [4:0] is a condition code here, not a register.
        dec_d.imm = {{(DATA_W-19){if_instr[23]}}, if_instr[23:5]};
      end
      OP_CBZ: begin
        dec_d.rd     = if_instr[4:0];
        dec_d.imm    = {{(DATA_W-19){if_instr[23]}}, if_instr[23:5]};
        dec_d.use_rd = 1'b1;
      end
      default: begin
        dec_d.illegal = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Holding register and handshake
  // ---------------------------------------------------------------------------
  dec_t hold_q;
  logic hold_valid_q, hold_valid_d;
  logic hazard;
  logic load, issue, push;

  assign id_valid = hold_valid_q && !hazard;

  // Gating with reset keeps if_ready low while reset is asserted even though
  // the holding register already reads empty.
  assign if_ready = !reset && !flush && (!hold_valid_q || (id_valid && id_ready));

  assign load  = if_valid && if_ready;
  // A flushed instruction never counts as issued.
  assign issue = id_valid && id_ready && !flush;
  assign push  = issue && (hold_q.op == OP_LDUR) && (hold_q.rd != XZR);

  always_comb begin : hold_valid_next
    hold_valid_d = hold_valid_q;
    if (flush) begin
      hold_valid_d = 1'b0;
    end else if (load) begin
      hold_valid_d = 1'b1;
    end else if (issue) begin
      hold_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin : hold_reg
    if (reset) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      // Fields only change on a load, so they stay stable while stalled.
      if (load) begin
        hold_q <= dec_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load scoreboard: slot 0 receives the issuing LDUR, every slot shifts each
  // cycle, and the entry falls off the end after LOAD_LAT cycles. Flush has no
  // effect here: loads already issued still complete.
  // ---------------------------------------------------------------------------
  logic [LOAD_LAT-1:0] sb_valid_q;
  logic [4:0]          sb_rd_q [LOAD_LAT];

  always_ff @(posedge clk or posedge reset) begin : sb_valid_reg
    if (reset) begin
      sb_valid_q <= '0;
    end else begin
      for (int i = LOAD_LAT - 1; i > 0; i--) begin
        sb_valid_q[i] <= sb_valid_q[i-1];
      end
      sb_valid_q[0] <= push;
    end
  end

  // NOTE: the rd payload is not reset; it is ignored whenever its valid bit
  // is clear, so only the valid bits need to be cleared.
  always_ff @(posedge clk) begin : sb_rd_reg
    for (int i = LOAD_LAT - 1; i > 0; i--) begin
      sb_rd_q[i] <= sb_rd_q[i-1];
    end
    sb_rd_q[0] <= hold_q.rd;
  end

  // X31 is never pushed, so a source of X31 can never match an entry.
  always_comb begin : hazard_check
    hazard = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (sb_valid_q[i] &&
          ((hold_q.use_rn && (hold_q.rn == sb_rd_q[i])) ||
           (hold_q.use_rm && (hold_q.rm == sb_rd_q[i])) ||
           (hold_q.use_rd && (hold_q.rd == sb_rd_q[i])))) begin
        hazard = 1'b1;
      end
    end
    hazard = hazard && hold_valid_q;
  end

  // ---------------------------------------------------------------------------
  // Stall counter (saturating)
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin : stall_counter
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (hold_valid_q && hazard && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign id_op       = hold_q.op;
  assign id_rd       = hold_q.rd;
  assign id_rn       = hold_q.rn;
  assign id_rm       = hold_q.rm;
  assign id_imm      = hold_q.imm;
  assign id_shamt    = hold_q.shamt;
  assign id_regwrite = hold_q.regwrite;
  assign id_memrd    = hold_q.memrd;
  assign id_memwr    = hold_q.memwr;
  assign id_setflags = hold_q.setflags;
  assign id_illegal  = hold_q.illegal;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  localparam int DATA_W   = 64;
  localparam int LOAD_LAT = 2;
  localparam int CNT_W    = 4;   // small so saturation is reachable
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_valid;
  logic [31:0]       if_instr;
  logic              if_ready;
  logic              flush;
  logic              id_ready;
  logic              id_valid;
  logic [3:0]        id_op;
  logic [4:0]        id_rd, id_rn, id_rm;
  logic [DATA_W-1:0] id_imm;
  logic [5:0]        id_shamt;
  logic              id_regwrite, id_memrd, id_memwr, id_setflags, id_illegal;
  logic [CNT_W-1:0]  stall_cnt;

  always #5 clk = ~clk;

  decode_stage #(.DATA_W(DATA_W), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
    .flush(flush), .id_ready(id_ready), .id_valid(id_valid),
    .id_op(id_op), .id_rd(id_rd), .id_rn(id_rn), .id_rm(id_rm),
    .id_imm(id_imm), .id_shamt(id_shamt),
    .id_regwrite(id_regwrite), .id_memrd(id_memrd), .id_memwr(id_memwr),
    .id_setflags(id_setflags), .id_illegal(id_illegal),
    .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rd, rn, rm;
    logic [63:0] imm;
    logic [5:0]  shamt;
    logic        rw, mr, mw, sf, ill;
  } dec_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    dec_t        exp;
  } vec_t;

  dec_t act;
  assign act = {id_op, id_rd, id_rn, id_rm, id_imm, id_shamt,
                id_regwrite, id_memrd, id_memwr, id_setflags, id_illegal};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, a, e);
    end
  endtask

  function automatic dec_t mk(input int op, input int rd, input int rn, input int rm,
                              input logic [63:0] imm, input int sh,
                              input bit rw, input bit mr, input bit mw, input bit sf, input bit ill);
    dec_t r;
    r.op = 4'(op); r.rd = 5'(rd); r.rn = 5'(rn); r.rm = 5'(rm);
    r.imm = imm; r.shamt = 6'(sh);
    r.rw = rw; r.mr = mr; r.mw = mw; r.sf = sf; r.ill = ill;
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [63:0] sext(input longint v, input int bits);
    longint m = longint'(1) << bits;
    longint x = v & (m - 1);
    if (x >= m / 2) x = x - m;
    return 64'(x);
  endfunction

  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t   r = '0;
    longint u = longint'({32'd0, w});
    int     op, rd, rn, rm, sh;
    if ((u >> 22) == 'h244)      op = 1;
    else if ((u >> 26) == 'h05)  op = 4;
    else if ((u >> 24) == 'h54)  op = 5;
    else if ((u >> 24) == 'hB4)  op = 6;
    else begin
      case (u >> 21)
        'h558:   op = 2;
        'h758:   op = 3;
        'h69B:   op = 9;
        'h69A:   op = 10;
`ifdef DECODE_MUL_EN
        'h4D8:   op = 11;
`endif
        'h7C0:   op = 8;
        'h7C2:   op = 7;
        default: op = 15;
      endcase
    end
    rd = int'(u % 32);
    rn = int'((u >> 5) % 32);
    rm = int'((u >> 16) % 32);
    sh = int'((u >> 10) % 64);
    case (op)
      1:         r = mk(1, rd, rn, 0, 64'((u >> 10) % 4096), 0, 1, 0, 0, 0, 0);
      2, 3:      r = mk(op, rd, rn, rm, 0, 0, 1, 0, 0, 1, 0);
      11:        r = mk(11, rd, rn, rm, 0, 0, 1, 0, 0, 0, 0);
      9, 10:     r = mk(op, rd, rn, 0, 0, sh, 1, 0, 0, 0, 0);
      7:         r = mk(7, rd, rn, 0, sext(u >> 12, 9), 0, 1, 1, 0, 0, 0);
      8:         r = mk(8, rd, rn, 0, sext(u >> 12, 9), 0, 0, 0, 1, 0, 0);
      4:         r = mk(4, 0, 0, 0, sext(u, 26), 0, 0, 0, 0, 0, 0);
      5:         r = mk(5, 0, 0, 0, sext(u >> 5, 19), 0, 0, 0, 0, 0, 0);
      6:         r = mk(6, rd, 0, 0, sext(u >> 5, 19), 0, 0, 0, 0, 0, 0);
      default:   r = mk(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endcase
    return r;
  endfunction

  // Register r is pending while the edge count is below busy_until[r].
  int cyc;
  int busy_until [32];

  function automatic bit ref_stalls(input dec_t h);
    int srcs[$];
    case (h.op)
      2, 3, 11:      begin srcs.push_back(int'(h.rn)); srcs.push_back(int'(h.rm)); end
      1, 7, 9, 10:   srcs.push_back(int'(h.rn));
      8:             begin srcs.push_back(int'(h.rn)); srcs.push_back(int'(h.rd)); end
      6:             srcs.push_back(int'(h.rd));
      default:       ;
    endcase
    foreach (srcs[i]) begin
      if (srcs[i] != 31 && cyc < busy_until[srcs[i]]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [4:0] pick_reg();
    int k = int'($urandom_range(0, 4));
    return (k == 4) ? 5'd31 : 5'(k);
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w = $urandom;
    int k = int'($urandom_range(0, 12));
    w[4:0] = pick_reg(); w[9:5] = pick_reg(); w[20:16] = pick_reg();
    case (k)
      0:       w[31:22] = 10'h244;
      1:       w[31:21] = 11'h558;
      2:       w[31:21] = 11'h758;
      3:       w[31:21] = 11'h69B;
      4:       w[31:21] = 11'h69A;
      5:       w[31:21] = 11'h4D8;
      6:       w[31:21] = 11'h7C0;
      7, 8:    w[31:21] = 11'h7C2;
      9:       w[31:26] = 6'h05;
      10:      w[31:24] = 8'h54;
      11:      w[31:24] = 8'hB4;
      default: ;
    endcase
    return w;
  endfunction

  task automatic do_reset();
    reset = 1'b1; if_valid = 1'b0; flush = 1'b0; id_ready = 1'b0; if_instr = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  localparam logic [31:0] I_LDUR_X2  = 32'hF85F8022;  // LDUR X2,[X1,#-8]
  localparam logic [31:0] I_ADDS_X2  = 32'hAB040043;  // ADDS X3,X2,X4
  localparam logic [31:0] I_LDUR_X31 = 32'hF85F803F;  // LDUR X31,[X1,#-8]
  localparam logic [31:0] I_ADDS_X31 = 32'hAB1F03E3;  // ADDS X3,X31,X31
  localparam logic [31:0] I_CBZ      = 32'hB40000A7;  // CBZ X7,#5

  vec_t vecs[13];
  dec_t held;
  bit   m_hv, hz, idv, ifr, iss;
  dec_t m_hold;
  int   m_stall;

  initial begin
    vecs[0]  = '{"addi",     32'h91001020, mk(1, 0, 1, 0, 64'd4, 0, 1, 0, 0, 0, 0)};
    vecs[1]  = '{"addi_zext",32'h913FFFFF, mk(1, 31, 31, 0, 64'hFFF, 0, 1, 0, 0, 0, 0)};
    vecs[2]  = '{"adds",     32'hAB040043, mk(2, 3, 2, 4, 64'd0, 0, 1, 0, 0, 1, 0)};
    vecs[3]  = '{"subs",     32'hEB070CC5, mk(3, 5, 6, 7, 64'd0, 0, 1, 0, 0, 1, 0)};
    vecs[4]  = '{"lsl",      32'hD37F1441, mk(9, 1, 2, 0, 64'd0, 5, 1, 0, 0, 0, 0)};
    vecs[5]  = '{"lsr",      32'hD340FC64, mk(10, 4, 3, 0, 64'd0, 63, 1, 0, 0, 0, 0)};
    vecs[6]  = '{"ldur",     32'hF85F8022, mk(7, 2, 1, 0, 64'hFFFF_FFFF_FFFF_FFF8, 0, 1, 1, 0, 0, 0)};
    vecs[7]  = '{"stur",     32'hF80FF149, mk(8, 9, 10, 0, 64'd255, 0, 0, 0, 1, 0, 0)};
    vecs[8]  = '{"b_neg1",   32'h17FFFFFF, mk(4, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 0, 0)};
    vecs[9]  = '{"blt_min",  32'h5480000B, mk(5, 0, 0, 0, 64'hFFFF_FFFF_FFFC_0000, 0, 0, 0, 0, 0, 0)};
    vecs[10] = '{"cbz",      32'hB40000A7, mk(6, 7, 0, 0, 64'd5, 0, 0, 0, 0, 0, 0)};
    vecs[11] = '{"illegal",  32'h00000000, mk(15, 0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 1)};
`ifdef DECODE_MUL_EN
    vecs[12] = '{"mul",      32'h9B027C20, mk(11, 0, 1, 2, 64'd0, 0, 1, 0, 0, 0, 0)};
`else
    vecs[12] = '{"mul",      32'h9B027C20, mk(15, 0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 1)};
`endif

    // Reset state
    reset = 1'b1; if_valid = 1'b1; if_instr = 32'h91001020; flush = 1'b0; id_ready = 1'b1;
    #1;
    check("rst_id_valid", 128'(id_valid), 128'(0));
    check("rst_if_ready", 128'(if_ready), 128'(0));
    check("rst_fields", 128'(act), 128'(0));
    check("rst_stall_cnt", 128'(stall_cnt), 128'(0));
    do_reset();

    // Table: each instruction alone, then drained so the scoreboard empties
    foreach (vecs[i]) begin
      if_valid = 1'b1; if_instr = vecs[i].instr; id_ready = 1'b1;
      @(posedge clk); #1;
      if_valid = 1'b0;
      @(negedge clk);
      check({vecs[i].name, "_valid"}, 128'(id_valid), 128'(1));
      check({vecs[i].name, "_fields"}, 128'(act), 128'(vecs[i].exp));
      repeat (LOAD_LAT + 1) @(negedge clk);
    end

    // Load-use stall: LDUR X2 then ADDS reading X2
    do_reset();
    if_valid = 1'b1; if_instr = I_LDUR_X2; id_ready = 1'b1;
    @(negedge clk);
    check("lu_ldur_valid", 128'(id_valid), 128'(1));
    if_instr = I_ADDS_X2;
    #1 check("lu_if_ready", 128'(if_ready), 128'(1));
    @(negedge clk);
    if_valid = 1'b0;
    check("lu_stall0_valid", 128'(id_valid), 128'(0));
    check("lu_stall0_cnt", 128'(stall_cnt), 128'(0));
    @(negedge clk);
    check("lu_stall1_valid", 128'(id_valid), 128'(0));
    check("lu_stall1_cnt", 128'(stall_cnt), 128'(1));
    @(negedge clk);
    check("lu_issue_valid", 128'(id_valid), 128'(1));
    check("lu_issue_op", 128'(id_op), 128'(2));
    check("lu_stall_cnt", 128'(stall_cnt), 128'(2));
    @(negedge clk);

    // X31 load never causes a stall
    do_reset();
    if_valid = 1'b1; if_instr = I_LDUR_X31; id_ready = 1'b1;
    @(negedge clk);
    if_instr = I_ADDS_X31;
    @(negedge clk);
    if_valid = 1'b0;
    check("xzr_valid", 128'(id_valid), 128'(1));
    check("xzr_op", 128'(id_op), 128'(2));
    @(negedge clk);
    check("xzr_stall_cnt", 128'(stall_cnt), 128'(0));

    // Backpressure on a held CBZ, then flush together with if_valid
    do_reset();
    if_valid = 1'b1; if_instr = I_CBZ; id_ready = 1'b0;
    @(negedge clk);
    if_instr = 32'h91001020;
    held = mk(6, 7, 0, 0, 64'd5, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_valid", 128'(id_valid), 128'(1));
      check("bp_if_ready", 128'(if_ready), 128'(0));
      check("bp_fields", 128'(act), 128'(held));
      @(negedge clk);
    end
    flush = 1'b1;
    #1 check("fl_if_ready", 128'(if_ready), 128'(0));
    @(negedge clk);
    flush = 1'b0; if_valid = 1'b0;
    #1;
    check("fl_id_valid", 128'(id_valid), 128'(0));
    check("fl_if_ready_after", 128'(if_ready), 128'(1));

    // Reset asserted mid-stall discards the held instruction
    do_reset();
    if_valid = 1'b1; if_instr = I_LDUR_X2; id_ready = 1'b1;
    @(negedge clk);
    if_instr = I_ADDS_X2;
    @(negedge clk);
    if_valid = 1'b0;
    check("mrst_stalled", 128'(id_valid), 128'(0));
    #2 reset = 1'b1;
    #1;
    check("mrst_id_valid", 128'(id_valid), 128'(0));
    check("mrst_if_ready", 128'(if_ready), 128'(0));
    check("mrst_fields", 128'(act), 128'(0));
    check("mrst_stall_cnt", 128'(stall_cnt), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mrst_discarded", 128'(id_valid), 128'(0));
    check("mrst_op_nop", 128'(id_op), 128'(0));

    // Randomised traffic against the reference model
    do_reset();
    m_hv = 1'b0; m_hold = '0; m_stall = 0; cyc = 0;
    foreach (busy_until[r]) busy_until[r] = 0;
    for (int n = 0; n < 800; n++) begin
      if_valid = ($urandom_range(0, 9) < 7);
      if_instr = gen_instr();
      flush    = ($urandom_range(0, 9) == 0);
      id_ready = ($urandom_range(0, 9) < 6);
      #1;
      hz  = m_hv && ref_stalls(m_hold);
      idv = m_hv && !hz;
      ifr = !flush && (!m_hv || (idv && id_ready));
      iss = idv && id_ready && !flush;
      check("rnd_id_valid", 128'(id_valid), 128'(idv));
      check("rnd_if_ready", 128'(if_ready), 128'(ifr));
      check("rnd_stall_cnt", 128'(stall_cnt), 128'(m_stall));
      check("rnd_fields", 128'(act), 128'(m_hold));
      @(posedge clk);
      cyc++;
      if (hz && m_stall < CNT_MAX) m_stall++;
      if (iss && m_hold.op == 4'd7 && m_hold.rd != 5'd31)
        busy_until[m_hold.rd] = cyc + LOAD_LAT;
      if (flush) m_hv = 1'b0;
      else if (if_valid && ifr) begin
        m_hold = ref_decode(if_instr);
        m_hv   = 1'b1;
      end else if (iss) m_hv = 1'b0;
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
